stream_proc: RTL and testbench

Parametrised successor to the 16-bit `processor`: a small register-file processor that consumes a stream of instruction and operand words on `data_in` and emits results on `data_out`. It adds valid/ready handshakes on both sides, a configurable data width and register count, and zero/carry flags. It sits between a word source (testbench or host FIFO) and a result sink, one word per accepted transfer.

---
 rtl/stream_proc.sv | 144 ++++++++++++++
 tb/tb_stream_proc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_proc.sv
// Register-file stream processor: instruction/operand words in via valid/ready,
// OUT results presented via valid/ready, with zero/carry flags from the ALU.
module stream_proc #(
   parameter int WIDTH = 16,
   parameter int NREGS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             zero,
   output logic             carry
);

   localparam int IW = $clog2(NREGS);

   typedef enum logic [1:0] {FETCH, EXEC, DATA, OUTW} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_op;
   logic [IW-1:0]    r_rd;
   logic [IW-1:0]    r_rs1;
   logic [IW-1:0]    r_rs2;
   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_dout;
   logic             r_zero;
   logic             r_carry;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH:0]   w_sum;
   logic             w_cout;
   logic             w_alu;
   logic             w_wr;
   logic             w_xfer;

   assign in_ready  = (r_state == FETCH) || (r_state == DATA);
   assign out_valid = (r_state == OUTW);
   assign data_out  = r_dout;
   assign zero      = r_zero;
   assign carry     = r_carry;
   assign w_xfer    = in_valid && in_ready;
   assign w_a       = r_regs[r_rs1];
   assign w_b       = r_regs[r_rs2];

   always_comb begin
      w_res  = '0;
      w_sum  = '0;
      w_cout = 1'b0;
      w_alu  = 1'b0;
      case (r_op)
         4'h2: begin
            w_sum  = {1'b0, w_a} + {1'b0, w_b};
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
            w_alu  = 1'b1;
         end
         4'h3: begin
            // The extra top bit of the widened difference is the borrow.
            w_sum  = {1'b0, w_a} - {1'b0, w_b};
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
            w_alu  = 1'b1;
         end
         4'h4: begin w_res = w_a & w_b; w_alu = 1'b1; end
         4'h5: begin w_res = w_a | w_b; w_alu = 1'b1; end
         4'h6: begin w_res = w_a ^ w_b; w_alu = 1'b1; end
         4'h7: begin w_res = ~w_a;      w_alu = 1'b1; end
         4'h8: begin
            w_res  = {w_a[WIDTH-2:0], 1'b0};
            w_cout = w_a[WIDTH-1];
            w_alu  = 1'b1;
         end
         4'h9: begin
            w_res  = {1'b0, w_a[WIDTH-1:1]};
            w_cout = w_a[0];
            w_alu  = 1'b1;
         end
         4'hB: w_res = w_a;
         default: ;
      endcase
   end

   assign w_wr = (r_state == EXEC) && (w_alu || (r_op == 4'hB));

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH: if (in_valid) w_next = EXEC;
         EXEC: begin
            case (r_op)
               4'h1:    w_next = DATA;
               4'hA:    w_next = OUTW;
               default: w_next = FETCH;
            endcase
         end
         DATA: if (in_valid) w_next = FETCH;
         OUTW: if (out_ready) w_next = FETCH;
         default: w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= FETCH;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op    <= '0;
         r_rd    <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_dout  <= '0;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if ((r_state == FETCH) && w_xfer) begin
            r_op  <= data_in[15:12];
            r_rd  <= data_in[8 +: IW];
            r_rs1 <= data_in[4 +: IW];
            r_rs2 <= data_in[0 +: IW];
         end
         if (w_wr)
            r_regs[r_rd] <= w_res;
         else if ((r_state == DATA) && w_xfer)
            r_regs[r_rd] <= data_in;
         if ((r_state == EXEC) && w_alu) begin
            r_zero  <= (w_res == '0);
            r_carry <= w_cout;
         end
         if ((r_state == EXEC) && (r_op == 4'hA))
            r_dout <= w_a;
      end
   end

endmodule

// File: tb/tb_stream_proc.sv
// Scoreboard bench for stream_proc: directed and random instruction streams
// against an arithmetic reference model; a WIDTH=32 instance covers wide data.
module tb_stream_proc;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_out;
   logic        out_valid;
   logic        out_ready;
   logic        zero;
   logic        carry;

   logic [31:0] d32_in;
   logic        d32_iv;
   logic        d32_ir;
   logic [31:0] d32_out;
   logic        d32_ov;
   logic        d32_z;
   logic        d32_c;

   always #5 clk = ~clk;

   stream_proc #(.WIDTH(16), .NREGS(4)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .zero(zero), .carry(carry)
   );

   stream_proc #(.WIDTH(32), .NREGS(8)) u_dut32 (
      .clk(clk), .rst(rst), .data_in(d32_in), .in_valid(d32_iv),
      .in_ready(d32_ir), .data_out(d32_out), .out_valid(d32_ov),
      .out_ready(1'b1), .zero(d32_z), .carry(d32_c)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        z;
      logic        c;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_regs[4];
   int unsigned m_z;
   int unsigned m_c;
   int unsigned checks = 0;
   int unsigned errors = 0;
   bit          bp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_z = 0;
      m_c = 0;
   endtask

   // Reference semantics in plain integer arithmetic on 16-bit values.
   task automatic model(input logic [15:0] w, input logic [15:0] opnd);
      int unsigned op, rd, a, b, res;
      bit          alu;
      op  = int'(w[15:12]);
      rd  = int'(w[11:8]) % 4;
      a   = m_regs[int'(w[7:4]) % 4];
      b   = m_regs[int'(w[3:0]) % 4];
      res = 0;
      alu = 1'b1;
      case (op)
         2: begin res = (a + b) % 65536; m_c = (a + b > 65535) ? 1 : 0; end
         3: begin res = (a + 65536 - b) % 65536; m_c = (a < b) ? 1 : 0; end
         4: begin res = a & b; m_c = 0; end
         5: begin res = a | b; m_c = 0; end
         6: begin res = a ^ b; m_c = 0; end
         7: begin res = 65535 - a; m_c = 0; end
         8: begin res = (a * 2) % 65536; m_c = (a >= 32768) ? 1 : 0; end
         9: begin res = a / 2; m_c = a % 2; end
         default: alu = 1'b0;
      endcase
      if (alu) begin
         m_regs[rd] = res;
         m_z = (res == 0) ? 1 : 0;
      end
      if (op == 1)  m_regs[rd] = int'(opnd);
      if (op == 11) m_regs[rd] = a;
      if (op == 10) sb.push_back('{d: a[15:0], z: m_z[0], c: m_c[0]});
   endtask

   task automatic send(input logic [15:0] w);
      int unsigned n;
      n = 0;
      @(negedge clk);
      data_in  = w;
      in_valid = 1'b1;
      while (!in_ready) begin
         @(negedge clk);
         n++;
         if (n > 1000) begin
            check("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic instr(input logic [15:0] w, input logic [15:0] opnd);
      model(w, opnd);
      send(w);
      if (w[15:12] == 4'h1) send(opnd);
   endtask

   task automatic send32(input logic [31:0] w);
      int unsigned n;
      n = 0;
      @(negedge clk);
      d32_in = w;
      d32_iv = 1'b1;
      while (!d32_ir) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            check("send32_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1 d32_iv = 1'b0;
   endtask

   task automatic expect32(input string name, input logic [31:0] d, input logic z, input logic c);
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!d32_ov && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, {31'd0, d32_ov}, 32'd1);
      check({name, "_data"}, d32_out, d);
      check({name, "_flags"}, {30'd0, d32_z, d32_c}, {30'd0, z, c});
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
      if (rst) begin
         check("excl_valid_ready", {31'd0, out_valid & in_ready}, 32'd0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", {16'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("out_data", {16'd0, data_out}, {16'd0, e.d});
               check("out_flags", {30'd0, zero, carry}, {30'd0, e.z, e.c});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;
      int unsigned n;
      logic [3:0]  op;
      logic [15:0] w;

      rst = 1'b0; in_valid = 1'b1; data_in = 16'h1100; out_ready = 1'b1;
      d32_in = '0; d32_iv = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_in_ready", {31'd0, in_ready}, 32'd1);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      end
      check("rst_data_out", {16'd0, data_out}, 32'd0);
      check("rst_flags", {30'd0, zero, carry}, 32'd0);
      rst = 1'b1; in_valid = 1'b0;
      instr(16'hA020, 16'h0);

      // Basic flow
      instr(16'h1100, 16'h0155);
      instr(16'h1200, 16'h002A);
      instr(16'h2312, 16'h0);
      instr(16'hA030, 16'h0);

      // Wrap and flags
      instr(16'h1000, 16'hFFFF);
      instr(16'h1100, 16'h0001);
      instr(16'h2201, 16'h0);
      instr(16'hA020, 16'h0);
      instr(16'h3310, 16'h0);
      instr(16'hA030, 16'h0);
      instr(16'h9310, 16'h0);
      instr(16'hA030, 16'h0);

      // Output backpressure: OUTW held, next word waits for the handshake
      instr(16'h1300, 16'h5A5A);
      @(posedge clk); #1 out_ready = 1'b0;
      instr(16'hA030, 16'h0);
      @(negedge clk);
      held = 16'h5A5A;
      in_valid = 1'b1; data_in = 16'hB130;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("hold_data", {16'd0, data_out}, {16'd0, held});
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("hs_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      model(16'hB130, 16'h0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("consumed_exec", {31'd0, in_ready}, 32'd0);
      instr(16'hA010, 16'h0);

      // Operand stall in DATA
      model(16'h1200, 16'hC3C3);
      send(16'h1200);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("data_wait_ready", {31'd0, in_ready}, 32'd1);
      end
      send(16'hC3C3);
      instr(16'hA020, 16'h0);

      // Reset between LOAD and its operand
      n = 0;
      while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
      send(16'h1100);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      model_reset();
      check("midload_rst_dout", {16'd0, data_out}, 32'd0);
      instr(16'hA010, 16'h0);

      // Register index taken modulo NREGS
      instr(16'h1500, 16'h1234);
      instr(16'hA010, 16'h0);

      // Random stream with random output backpressure
      bp_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         w  = 16'($urandom);
         op = ($urandom_range(0, 3) == 0) ? 4'hA : 4'($urandom_range(0, 15));
         instr({op, w[11:0]}, 16'($urandom));
      end
      bp_en = 1'b0;
      @(posedge clk); #1 out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      check("drain", sb.size(), 32'd0);

      // WIDTH=32 / NREGS=8 instance
      send32(32'h0000_1000); send32(32'hFFFF_FFFF);
      send32(32'h0000_1100); send32(32'h0000_0001);
      send32(32'h0000_2201);
      send32(32'h0000_A020);
      expect32("w32_add", 32'h0, 1'b1, 1'b1);
      send32(32'hFFFF_A010);
      expect32("w32_hibits", 32'h1, 1'b1, 1'b1);
      send32(32'h0000_1500); send32(32'h4000_0000);
      send32(32'h0000_8650);
      send32(32'h0000_A060);
      expect32("w32_shl", 32'h8000_0000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
